// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants and helpers for the DVI/VGA pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIXEL_W      = 24;
    localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

    // Field positions inside a {r,g,b} pixel word.
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : Small circular buffer absorbing ROM read latency. Caller
//               guarantees push only when a slot exists and pop only when
//               non-empty; clear drops all contents in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import vga_pkg::*;
#(
    parameter  int DEPTH = 3,
    parameter  int WIDTH = 25,
    localparam int CNT_W = cnt_width(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/frame_fetch.sv
`default_nettype none
// ============================================================================
// Module      : frame_fetch
// Description : Walks a linear framebuffer in the pattern ROM, issues
//               pipelined reads under a credit scheme, lands returns in a
//               skid buffer and pushes RGB words into the pixel FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_fetch
    import vga_pkg::*;
#(
    parameter int               H_ACTIVE  = H_ACTIVE_DEF,
    parameter int               V_ACTIVE  = V_ACTIVE_DEF,
    parameter int               ADDR_W    = 24,
    parameter int               DATA_W    = PIXEL_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int               ROM_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              resync,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              frame_done,
    output logic              busy
);

    localparam int SKID_DEPTH = ROM_LAT + 1;
    localparam int FRAME      = H_ACTIVE * V_ACTIVE;
    localparam int PIX_W      = cnt_width(FRAME);
    localparam int CNT_W      = cnt_width(SKID_DEPTH + 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME - 1);

    logic               armed;
    logic [PIX_W-1:0]   pix;
    logic [CNT_W-1:0]   inflight;
    logic [ROM_LAT-1:0] vld_pipe;
    logic [ROM_LAT-1:0] last_pipe;
    logic [ROM_LAT-1:0] disc_pipe;

    logic [CNT_W-1:0]   skid_count;
    logic               skid_empty;
    logic               skid_full;
    logic [DATA_W:0]    head_word;

    logic [CNT_W:0]     occ;
    logic               credit_ok;
    logic               issue;
    logic               pop;
    logic               ret;
    logic               store;
    logic               push;

    // Credit check and per-cycle handshakes. A pop this cycle frees a slot
    // before any read issued now can return, so it counts as a credit and
    // lets the stream sustain one pixel per cycle.
    always_comb begin
        pop       = !skid_empty && !fifo_full && !resync;
        occ       = (CNT_W+1)'(inflight) + (CNT_W+1)'(skid_count) - (CNT_W+1)'(pop);
        credit_ok = (occ < (CNT_W+1)'(SKID_DEPTH));
        issue     = armed && enable && !resync && credit_ok;
        ret       = vld_pipe[ROM_LAT-1];
        store     = ret && !disc_pipe[ROM_LAT-1] && !resync;
        push      = store && (!skid_full || pop);
    end

    // Pixel counter, in-flight read count and post-reset arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            pix      <= '0;
            inflight <= '0;
        end else begin
            armed <= 1'b1;
            if (resync) begin
                pix <= '0;
            end else if (issue) begin
                pix <= (pix == LAST_PIX) ? '0 : pix + 1'b1;
            end
            // Discarded reads keep their credit until they emerge.
            inflight <= inflight + CNT_W'(issue) - CNT_W'(ret);
        end
    end

    // Valid / last-of-frame / discard sideband matching ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            disc_pipe <= '0;
        end else begin
            vld_pipe[0]  <= issue;
            last_pipe[0] <= (pix == LAST_PIX);
            disc_pipe[0] <= 1'b0;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                disc_pipe[i] <= disc_pipe[i-1] | resync;
            end
        end
    end

    fetch_skid_buf #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (resync),
        .push      (push),
        .push_data ({last_pipe[ROM_LAT-1], rom_rdata}),
        .pop       (pop),
        .head      (head_word),
        .count     (skid_count),
        .empty     (skid_empty),
        .full      (skid_full)
    );

    assign rom_rd_en  = issue;
    assign rom_addr   = issue ? (BASE_ADDR + ADDR_W'(pix)) : '0;
    assign fifo_wr_en = pop;
    assign fifo_wdata = head_word[DATA_W-1:0];
    assign frame_done = pop && head_word[DATA_W];
    assign busy       = (inflight != '0) || (skid_count != '0);

endmodule
`default_nettype wire
